// File: rtl/mmu_pkg.sv
// Shared constants and entry-layout helpers for the segment decoder and TLB.
// Entry layout, MSB first: {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}.
package mmu_pkg;

    localparam logic [2:0] SEG_KSEG0  = 3'b100;
    localparam logic [2:0] SEG_KSEG1  = 3'b101;
    localparam logic [2:0] CCA_CACHED = 3'b011;

    localparam int unsigned VPN2_W = 19;
    localparam int unsigned CCA_W  = 3;

    function automatic int unsigned pfn_w(input int unsigned pa_w);
        return pa_w - 12;
    endfunction

    // One page half is {pfn, c[2:0], d, v}.
    function automatic int unsigned half_w(input int unsigned pfn_width);
        return pfn_width + CCA_W + 2;
    endfunction

    function automatic int unsigned entry_w(input int unsigned asid_w, input int unsigned pa_w);
        return VPN2_W + asid_w + 1 + 2 * half_w(pfn_w(pa_w));
    endfunction

    function automatic int unsigned g_lsb(input int unsigned pa_w);
        return 2 * half_w(pfn_w(pa_w));
    endfunction

    function automatic int unsigned asid_lsb(input int unsigned pa_w);
        return g_lsb(pa_w) + 1;
    endfunction

    function automatic int unsigned vpn2_lsb(input int unsigned asid_w, input int unsigned pa_w);
        return asid_lsb(pa_w) + asid_w;
    endfunction

    localparam int unsigned DEF_ASID_W  = 8;
    localparam int unsigned DEF_PA_W    = 32;
    localparam int unsigned DEF_PFN_W   = pfn_w(DEF_PA_W);
    localparam int unsigned DEF_ENTRY_W = entry_w(DEF_ASID_W, DEF_PA_W);

    // Field view of an entry in the default configuration, for CP0-side software models.
    typedef struct packed {
        logic [VPN2_W-1:0]     vpn2;
        logic [DEF_ASID_W-1:0] asid;
        logic                  g;
        logic [DEF_PFN_W-1:0]  pfn0;
        logic [CCA_W-1:0]      c0;
        logic                  d0;
        logic                  v0;
        logic [DEF_PFN_W-1:0]  pfn1;
        logic [CCA_W-1:0]      c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

    function automatic logic [DEF_ENTRY_W-1:0] pack_entry(input tlb_entry_t e);
        return e;
    endfunction

    function automatic tlb_entry_t unpack_entry(input logic [DEF_ENTRY_W-1:0] bits);
        return tlb_entry_t'(bits);
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully-associative VPN2/ASID compare across all entries with a lowest-index-wins encoder.
module tlb_match
    import mmu_pkg::*;
#(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned ASID_W = 8,
    localparam int unsigned IDX_W = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0]             i_present,
    input  logic [TLBNUM-1:0][VPN2_W-1:0] i_vpn2,
    input  logic [TLBNUM-1:0][ASID_W-1:0] i_asid,
    input  logic [TLBNUM-1:0]             i_g,
    input  logic [VPN2_W-1:0]             i_key_vpn2,
    input  logic [ASID_W-1:0]             i_key_asid,
    output logic                          o_found,
    output logic [IDX_W-1:0]              o_index
);

    logic [TLBNUM-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            w_hit[i] = i_present[i] && (i_vpn2[i] == i_key_vpn2) &&
                       (i_g[i] || (i_asid[i] == i_key_asid));
        end
    end

    // Scanning downward lets the lowest matching index overwrite any higher one.
    always_comb begin
        o_found = |w_hit;
        o_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Virtual-to-physical translation: fixed kseg0/kseg1 mapping, software-managed TLB elsewhere.
// Lookup and probe results are registered; TLBWI/TLBR/TLBP are driven by CP0.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned ASID_W = 8,
    parameter int unsigned PA_W   = 32,
    localparam int unsigned IDX_W   = $clog2(TLBNUM),
    localparam int unsigned PFN_W   = pfn_w(PA_W),
    localparam int unsigned ENTRY_W = entry_w(ASID_W, PA_W)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic [31:0]        req_vaddr,
    input  logic               req_store,
    input  logic [ASID_W-1:0]  cur_asid,
    input  logic [2:0]         k0_cca,
    output logic               resp_valid,
    output logic [PA_W-1:0]    resp_paddr,
    output logic               resp_cached,
    output logic               resp_refill,
    output logic               resp_invalid,
    output logic               resp_modified,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [ENTRY_W-1:0] rd_entry,
    input  logic               probe_en,
    input  logic [VPN2_W-1:0]  probe_vpn2,
    input  logic [ASID_W-1:0]  probe_asid,
    output logic               probe_done,
    output logic               probe_hit,
    output logic [IDX_W-1:0]   probe_index
);

    localparam int unsigned HALF_W   = half_w(PFN_W);
    localparam int unsigned G_LSB    = g_lsb(PA_W);
    localparam int unsigned ASID_LSB = asid_lsb(PA_W);
    localparam int unsigned VPN2_LSB = vpn2_lsb(ASID_W, PA_W);

    logic [ENTRY_W-1:0] r_entry [TLBNUM];
    logic [TLBNUM-1:0]  r_present;

    logic [TLBNUM-1:0][VPN2_W-1:0] w_vpn2;
    logic [TLBNUM-1:0][ASID_W-1:0] w_asid;
    logic [TLBNUM-1:0]             w_g;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            w_vpn2[i] = r_entry[i][VPN2_LSB +: VPN2_W];
            w_asid[i] = r_entry[i][ASID_LSB +: ASID_W];
            w_g[i]    = r_entry[i][G_LSB];
        end
    end

    logic             w_lk_found;
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_pr_found;
    logic [IDX_W-1:0] w_pr_idx;

    tlb_match #(
        .TLBNUM (TLBNUM),
        .ASID_W (ASID_W)
    ) u_lookup_match (
        .i_present  (r_present),
        .i_vpn2     (w_vpn2),
        .i_asid     (w_asid),
        .i_g        (w_g),
        .i_key_vpn2 (req_vaddr[31:13]),
        .i_key_asid (cur_asid),
        .o_found    (w_lk_found),
        .o_index    (w_lk_idx)
    );

    tlb_match #(
        .TLBNUM (TLBNUM),
        .ASID_W (ASID_W)
    ) u_probe_match (
        .i_present  (r_present),
        .i_vpn2     (w_vpn2),
        .i_asid     (w_asid),
        .i_g        (w_g),
        .i_key_vpn2 (probe_vpn2),
        .i_key_asid (probe_asid),
        .o_found    (w_pr_found),
        .o_index    (w_pr_idx)
    );

    // vaddr[12] picks the odd page (low half of the entry) or the even page.
    logic [HALF_W-1:0] w_page;
    logic [PFN_W-1:0]  w_pfn;
    logic [2:0]        w_c;
    logic              w_d;
    logic              w_v;

    always_comb begin
        w_page = req_vaddr[12] ? r_entry[w_lk_idx][HALF_W-1:0]
                               : r_entry[w_lk_idx][2*HALF_W-1:HALF_W];
        w_pfn  = w_page[HALF_W-1:5];
        w_c    = w_page[4:2];
        w_d    = w_page[1];
        w_v    = w_page[0];
    end

    logic [PA_W-1:0] w_paddr;
    logic            w_cached;
    logic            w_refill;
    logic            w_invalid;
    logic            w_modified;

    always_comb begin
        w_paddr    = PA_W'(req_vaddr[28:0]);
        w_cached   = 1'b0;
        w_refill   = 1'b0;
        w_invalid  = 1'b0;
        w_modified = 1'b0;
        case (req_vaddr[31:29])
            SEG_KSEG0: w_cached = (k0_cca == CCA_CACHED);
            SEG_KSEG1: w_cached = 1'b0;
            default: begin
                if (!w_lk_found) begin
                    w_refill = 1'b1;
                    w_paddr  = '0;
                end else begin
                    w_paddr    = {w_pfn, req_vaddr[11:0]};
                    w_cached   = (w_c == CCA_CACHED);
                    w_invalid  = !w_v;
                    w_modified = req_store && w_v && !w_d;
                end
            end
        endcase
    end

    // Payload is not reset; only the present bits gate matching.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_entry[wr_index] <= wr_entry;
        end
    end

    logic               r_resp_valid;
    logic [PA_W-1:0]    r_resp_paddr;
    logic               r_resp_cached;
    logic               r_resp_refill;
    logic               r_resp_invalid;
    logic               r_resp_modified;
    logic [ENTRY_W-1:0] r_rd_entry;
    logic               r_probe_done;
    logic               r_probe_hit;
    logic [IDX_W-1:0]   r_probe_index;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_present       <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_paddr    <= '0;
            r_resp_cached   <= 1'b0;
            r_resp_refill   <= 1'b0;
            r_resp_invalid  <= 1'b0;
            r_resp_modified <= 1'b0;
            r_rd_entry      <= '0;
            r_probe_done    <= 1'b0;
            r_probe_hit     <= 1'b0;
            r_probe_index   <= '0;
        end else begin
            if (wr_en) begin
                r_present[wr_index] <= 1'b1;
            end
            r_resp_valid <= req_valid;
            if (req_valid) begin
                r_resp_paddr    <= w_paddr;
                r_resp_cached   <= w_cached;
                r_resp_refill   <= w_refill;
                r_resp_invalid  <= w_invalid;
                r_resp_modified <= w_modified;
            end
            r_rd_entry   <= r_entry[rd_index];
            r_probe_done <= probe_en;
            if (probe_en) begin
                r_probe_hit   <= w_pr_found;
                r_probe_index <= w_pr_found ? w_pr_idx : '0;
            end
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_paddr    = r_resp_paddr;
    assign resp_cached   = r_resp_cached;
    assign resp_refill   = r_resp_refill;
    assign resp_invalid  = r_resp_invalid;
    assign resp_modified = r_resp_modified;
    assign rd_entry      = r_rd_entry;
    assign probe_done    = r_probe_done;
    assign probe_hit     = r_probe_hit;
    assign probe_index   = r_probe_index;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed and random checks of mmu_tlb against a field-level reference model.
module tb_mmu_tlb;

    localparam int TLBNUM  = 16;
    localparam int ASID_W  = 8;
    localparam int PA_W    = 32;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = 78;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tb_ent_t;

    logic               clk = 1'b0;
    logic               resetn;
    logic               req_valid;
    logic [31:0]        req_vaddr;
    logic               req_store;
    logic [ASID_W-1:0]  cur_asid;
    logic [2:0]         k0_cca;
    logic               resp_valid;
    logic [PA_W-1:0]    resp_paddr;
    logic               resp_cached;
    logic               resp_refill;
    logic               resp_invalid;
    logic               resp_modified;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_index;
    logic [ENTRY_W-1:0] wr_entry;
    logic [IDX_W-1:0]   rd_index;
    logic [ENTRY_W-1:0] rd_entry;
    logic               probe_en;
    logic [18:0]        probe_vpn2;
    logic [ASID_W-1:0]  probe_asid;
    logic               probe_done;
    logic               probe_hit;
    logic [IDX_W-1:0]   probe_index;

    mmu_tlb #(
        .TLBNUM (TLBNUM),
        .ASID_W (ASID_W),
        .PA_W   (PA_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_vaddr     (req_vaddr),
        .req_store     (req_store),
        .cur_asid      (cur_asid),
        .k0_cca        (k0_cca),
        .resp_valid    (resp_valid),
        .resp_paddr    (resp_paddr),
        .resp_cached   (resp_cached),
        .resp_refill   (resp_refill),
        .resp_invalid  (resp_invalid),
        .resp_modified (resp_modified),
        .wr_en         (wr_en),
        .wr_index      (wr_index),
        .wr_entry      (wr_entry),
        .rd_index      (rd_index),
        .rd_entry      (rd_entry),
        .probe_en      (probe_en),
        .probe_vpn2    (probe_vpn2),
        .probe_asid    (probe_asid),
        .probe_done    (probe_done),
        .probe_hit     (probe_hit),
        .probe_index   (probe_index)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [ENTRY_W-1:0] m_bits    [TLBNUM];
    logic               m_present [TLBNUM];
    logic               m_written [TLBNUM];

    // Expected registered outputs.
    logic               e_valid, e_cached, e_refill, e_invalid, e_modified;
    logic [31:0]        e_paddr;
    logic               e_pdone, e_phit;
    logic [3:0]         e_pidx;
    logic               e_rd_known;
    logic [ENTRY_W-1:0] e_rd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(
        input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
        input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TLBNUM; i++) begin
            m_present[i] = 1'b0;
            m_written[i] = 1'b0;
        end
        e_valid = 0; e_paddr = 0; e_cached = 0; e_refill = 0; e_invalid = 0; e_modified = 0;
        e_pdone = 0; e_phit = 0; e_pidx = 0; e_rd_known = 0; e_rd = '0;
    endtask

    task automatic model_find(input logic [18:0] vpn2, input logic [7:0] asid,
                              output logic found, output int idx);
        tb_ent_t e;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < TLBNUM; i++) begin
            e = tb_ent_t'(m_bits[i]);
            if (!found && m_present[i] && e.vpn2 == vpn2 && (e.g || e.asid == asid)) begin
                found = 1'b1;
                idx = i;
            end
        end
    endtask

    task automatic model_lookup(input logic [31:0] va, input logic st, input logic [7:0] asid,
                                input logic [2:0] k0);
        logic found;
        int idx;
        tb_ent_t e;
        logic [19:0] pfn;
        logic [2:0] c;
        logic d, v;
        e_refill = 0; e_invalid = 0; e_modified = 0;
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
            e_paddr = va & 32'h1FFF_FFFF;
            e_cached = (va[31:29] == 3'b100) && (k0 == 3'd3);
        end else begin
            model_find(va[31:13], asid, found, idx);
            if (!found) begin
                e_refill = 1;
                e_paddr = 0;
                e_cached = 0;
            end else begin
                e = tb_ent_t'(m_bits[idx]);
                pfn = va[12] ? e.pfn1 : e.pfn0;
                c = va[12] ? e.c1 : e.c0;
                d = va[12] ? e.d1 : e.d0;
                v = va[12] ? e.v1 : e.v0;
                e_paddr = {pfn, va[11:0]};
                e_cached = (c == 3'd3);
                if (!v) e_invalid = 1;
                else if (st && !d) e_modified = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("resp_valid", resp_valid, e_valid);
        chk("resp_paddr", resp_paddr, e_paddr);
        chk("resp_refill", resp_refill, e_refill);
        chk("resp_invalid", resp_invalid, e_invalid);
        chk("resp_modified", resp_modified, e_modified);
        if (!e_refill) chk("resp_cached", resp_cached, e_cached);
        chk("probe_done", probe_done, e_pdone);
        if (e_pdone) begin
            chk("probe_hit", probe_hit, e_phit);
            chk("probe_index", probe_index, e_pidx);
        end
        if (e_rd_known) chk("rd_entry", rd_entry, e_rd);
    endtask

    // Expectations use pre-edge model contents; the write lands after them.
    task automatic cycle();
        logic found;
        int idx;
        e_valid = req_valid;
        if (req_valid) model_lookup(req_vaddr, req_store, cur_asid, k0_cca);
        e_pdone = probe_en;
        if (probe_en) begin
            model_find(probe_vpn2, probe_asid, found, idx);
            e_phit = found;
            e_pidx = found ? 4'(idx) : 4'd0;
        end
        e_rd_known = m_written[rd_index];
        e_rd = m_bits[rd_index];
        if (wr_en) begin
            m_bits[wr_index] = wr_entry;
            m_present[wr_index] = 1'b1;
            m_written[wr_index] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [18:0] pick_vpn2();
        case ($urandom_range(0, 3))
            0: return 19'h00200;
            1: return 19'h00201;
            2: return 19'h60000;
            default: return 19'h7FFFF;
        endcase
    endfunction

    logic [ENTRY_W-1:0] ent3;

    initial begin
        resetn = 1; req_valid = 0; req_vaddr = 0; req_store = 0; cur_asid = 0; k0_cca = 0;
        wr_en = 0; wr_index = 0; wr_entry = '0; rd_index = 0;
        probe_en = 0; probe_vpn2 = 0; probe_asid = 0;
        model_reset();
        #1 resetn = 0;
        #2;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_paddr", resp_paddr, 0);
        chk("rst_probe_done", probe_done, 0);
        chk("rst_probe_hit", probe_hit, 0);
        chk("rst_rd_entry", rd_entry, 0);
        @(posedge clk);
        #1 resetn = 1;

        // kseg0 / kseg1
        req_valid = 1; req_vaddr = 32'h8000_1234; k0_cca = 3'd3;
        cycle();
        chk("kseg0_pa", resp_paddr, 32'h0000_1234);
        chk("kseg0_cached", resp_cached, 1);
        req_vaddr = 32'hBFC0_0000;
        cycle();
        chk("kseg1_pa", resp_paddr, 32'h1FC0_0000);
        chk("kseg1_cached", resp_cached, 0);
        chk("kseg1_faults", {resp_refill, resp_invalid, resp_modified}, 0);

        // Empty TLB miss
        req_vaddr = 32'h0040_0000;
        cycle();
        chk("empty_refill", resp_refill, 1);
        chk("empty_pa", resp_paddr, 0);

        // TLBWI idx 3
        req_valid = 0; cur_asid = 8'd5;
        ent3 = mk(19'h00200, 8'd5, 0, 20'h12345, 3'd3, 1, 1, 20'h54321, 3'd2, 0, 1);
        wr_en = 1; wr_index = 4'd3; wr_entry = ent3;
        cycle();
        chk("idle_valid", resp_valid, 0);
        wr_en = 0;
        req_valid = 1; req_vaddr = 32'h0040_0ABC; req_store = 0;
        cycle();
        chk("hit_pa", resp_paddr, 32'h1234_5ABC);
        chk("hit_cached", resp_cached, 1);
        req_vaddr = 32'h0040_1ABC; req_store = 1;
        cycle();
        chk("store_modified", resp_modified, 1);
        req_store = 0; cur_asid = 8'd6; req_vaddr = 32'h0040_0ABC;
        cycle();
        chk("asid_refill", resp_refill, 1);

        // Rewrite as global with v0=0, lookup in the same cycle sees the old entry
        ent3 = mk(19'h00200, 8'd5, 1, 20'h12345, 3'd3, 1, 0, 20'h54321, 3'd2, 0, 1);
        cur_asid = 8'd5; req_vaddr = 32'h0040_0000;
        wr_en = 1; wr_index = 4'd3; wr_entry = ent3;
        cycle();
        chk("wr_same_cycle_pa", resp_paddr, 32'h1234_5000);
        chk("wr_same_cycle_inv", resp_invalid, 0);
        wr_en = 0; cur_asid = 8'hA7;
        cycle();
        chk("global_invalid", resp_invalid, 1);

        // Duplicate VPN2 at idx 9; probes and TLBR
        req_valid = 0;
        wr_en = 1; wr_index = 4'd9;
        wr_entry = mk(19'h00200, 8'd5, 1, 20'hAAAAA, 3'd3, 1, 1, 20'hBBBBB, 3'd3, 1, 1);
        cycle();
        wr_en = 0;
        probe_en = 1; probe_vpn2 = 19'h00200; probe_asid = 8'd5; rd_index = 4'd3;
        cycle();
        chk("probe_hit_dup", probe_hit, 1);
        chk("probe_idx_dup", probe_index, 3);
        chk("tlbr_idx3", rd_entry, ent3);
        probe_vpn2 = 19'h12345;
        cycle();
        chk("probe_miss_hit", probe_hit, 0);
        chk("probe_miss_idx", probe_index, 0);
        probe_en = 0;

        // Reset in flight
        req_valid = 1; req_vaddr = 32'h0040_1ABC; cur_asid = 8'd5;
        cycle();
        #2 resetn = 0;
        #1;
        model_reset();
        chk("rst_mid_valid", resp_valid, 0);
        chk("rst_mid_pa", resp_paddr, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", resp_valid, 0);
        resetn = 1;
        cycle();
        chk("post_rst_refill", resp_refill, 1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                req_vaddr = {2'b10, 1'($urandom), 29'($urandom)};
            else
                req_vaddr = {pick_vpn2(), 13'($urandom)};
            req_store = 1'($urandom);
            cur_asid = 8'($urandom_range(5, 7));
            k0_cca = 3'($urandom_range(2, 4));
            wr_en = ($urandom_range(0, 3) == 0);
            wr_index = 4'($urandom);
            wr_entry = mk(pick_vpn2(), 8'($urandom_range(5, 7)), ($urandom_range(0, 3) == 0),
                          20'($urandom), 3'($urandom_range(2, 4)), 1'($urandom), 1'($urandom),
                          20'($urandom), 3'($urandom_range(2, 4)), 1'($urandom), 1'($urandom));
            probe_en = 1'($urandom);
            probe_vpn2 = ($urandom_range(0, 4) == 0) ? 19'($urandom) : pick_vpn2();
            probe_asid = 8'($urandom_range(5, 7));
            rd_index = 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
Parametrised successor to the fixed-segment address mapper: translates 32-bit virtual addresses to physical addresses.
- kseg0/kseg1 keep the fixed unmapped mapping.
- kuseg/kseg2/kseg3 translate through a fully-associative, software-managed TLB of TLBNUM even/odd 4 KB page pairs, with ASID matching and refill/invalid/modify fault flags.
- Sits between the fetch/LSU address stage and the cache/AXI bridge; CP0 drives TLBWI/TLBR/TLBP.

Parameters:
TLBNUM, 16, number of TLB entries (power of 2, 2..64)
ASID_W, 8, ASID width
PA_W, 32, physical address width (>=29); PFN_W = PA_W-12
ENTRY_W, derived = 19+ASID_W+1+2*(PFN_W+5), packed entry width {vpn2[18:0], asid, g, pfn0, c0[2:0], d0, v0, pfn1, c1[2:0], d1, v1}

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  lookup request
req_vaddr  in  32  virtual address
req_store  in  1  request is a store (modify check)
cur_asid  in  ASID_W  current ASID (CP0 EntryHi)
k0_cca  in  3  CP0 Config.K0
resp_valid  out  1  lookup result valid
resp_paddr  out  PA_W  physical address
resp_cached  out  1  1 = cacheable
resp_refill  out  1  TLB miss in mapped segment
resp_invalid  out  1  hit, selected page V=0
resp_modified  out  1  store hit, V=1, D=0
wr_en  in  1  TLBWI strobe
wr_index  in  log2(TLBNUM)  entry to write
wr_entry  in  ENTRY_W  packed entry
rd_index  in  log2(TLBNUM)  TLBR index
rd_entry  out  ENTRY_W  registered TLBR data
probe_en  in  1  TLBP strobe
probe_vpn2  in  19  VPN2 to probe
probe_asid  in  ASID_W  ASID to probe
probe_done  out  1  probe result valid
probe_hit  out  1  probe matched
probe_index  out  log2(TLBNUM)  matched index

Behaviour:
- Reset (async, resetn=0): all entry-present bits cleared; resp_* , probe_*, rd_entry = 0. Entry payload RAM need not be reset.
- Segment decode on req_vaddr[31:29]:
  - 100 (kseg0): paddr = zero-extended {3'b000, vaddr[28:0]}; cached = (k0_cca==3'b011).
  - 101 (kseg1): same paddr; cached = 0.
  - Otherwise: mapped.
- Mapped lookup:
  - Entry i matches when present_i && vpn2_i==vaddr[31:13] && (g_i || asid_i==cur_asid).
  - vaddr[12] selects the odd (1) or even (0) page.
  - paddr = {pfn_sel, vaddr[11:0]}; cached = (c_sel==3'b011).
  - Multiple matches: lowest index wins, so the result is deterministic.
- Faults (mapped only, mutually exclusive, priority refill > invalid > modified):
  - No match: refill=1, paddr=0.
  - v_sel=0: invalid=1.
  - req_store && v_sel && !d_sel: modified=1.
- Latency: registered, 1 cycle. resp_valid(t+1) = req_valid(t). Other resp_* update only when req_valid=1; otherwise they hold.
- Back-to-back requests supported every cycle; there is no back-pressure.
- TLBWI: on a wr_en edge, entry[wr_index] <= wr_entry and present <= 1.
  - A lookup or probe in the same cycle sees pre-write contents; the next cycle sees the new entry.
- TLBR: rd_entry <= entry[rd_index] every cycle (1-cycle latency). rd_entry is don't-care for never-written entries.
- TLBP: probe_done(t+1) = probe_en(t). Match uses the same rule with probe_vpn2/probe_asid; lowest index wins. probe_index = 0 when probe_hit=0.
- Reset mid-operation: pending resp/probe results are discarded and outputs go to 0 immediately.
- cur_asid change takes effect on the next sampled request. No stale-ASID caching.

Decomposition:
- Shared package mmu_pkg: segment codes, CCA_CACHED=3'b011, entry field offset/width constants and pack/unpack functions, and derived ENTRY_W/PFN_W.
- One sub-module, tlb_match: combinational TLBNUM-way compare plus priority encoder (found, index), instantiated twice (lookup and probe).

Test Plan:
- Reset, then kseg0/kseg1: vaddr 0x8000_1234 with k0_cca=3 -> next cycle paddr 0x0000_1234, cached=1; vaddr 0xBFC0_0000 -> paddr 0x1FC0_0000, cached=0; no fault flags.
- Empty TLB after reset, lookup 0x0040_0000 -> resp_refill=1, paddr=0.
- Write idx 3 {vpn2=0x00200, asid=5, g=0, pfn0=0x12345, c0=3, v0=1, d0=1, pfn1=0x54321, c1=2, v1=1, d1=0}, cur_asid=5:
  - Lookup 0x0040_0ABC -> paddr 0x1234_5ABC, cached=1.
  - Store to 0x0040_1ABC -> modified=1.
  - cur_asid=6 -> refill=1.
- Same entry rewritten with g=1, v0=0: lookup 0x0040_0000 with any ASID -> invalid=1. Write and lookup in the same cycle -> lookup returns the old result.
- Probe vpn2=0x00200, asid=5 after idx 3 and idx 9 hold the same VPN2 -> probe_hit=1, index=3. Unmatched probe -> hit=0, index=0. TLBR idx 3 returns the written entry.
- resetn pulsed low between req_valid and resp -> resp_valid=0. Subsequent lookup of previously-written VA -> refill=1.
